// File: rtl/mod_addsub_if.sv
// mod_addsub_if: request/response bundle for the limb-serial modular adder.
//   start  - request strobe (master -> slave)
//   op     - 0 = add, 1 = subtract (master -> slave)
//   a, b   - WIDTH-bit operands (master -> slave)
//   result - WIDTH-bit registered result (slave -> master)
//   done   - one-cycle completion pulse (slave -> master)
//   busy   - operation in flight (slave -> master)
interface mod_addsub_if #(
  parameter int WIDTH = 448
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;

  modport master (
    output start, op, a, b,
    input  result, done, busy
  );

  modport slave (
    input  start, op, a, b,
    output result, done, busy
  );
endinterface

// File: rtl/mod_addsub.sv
// parameters_pkg: shared field parameters (448-bit Goldilocks prime).
//
// mod_addsub: (a + b) mod MODULUS or (a - b) mod MODULUS, one LIMB_WIDTH-bit
// limb per cycle, LSB limb first. Both the plain result s and the corrected
// result t (s -/+ MODULUS) are built in parallel; the final carry/borrow
// chooses between them.
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - mod_addsub_if slave: start/op/a/b in, result/done/busy out
package parameters_pkg;
  localparam int DATA_WIDTH = 448;
  // 2^448 - 2^224 - 1
  localparam logic [DATA_WIDTH-1:0] MODULUS = {{223{1'b1}}, 1'b0, {224{1'b1}}};
endpackage

module mod_addsub #(
  parameter int               WIDTH      = parameters_pkg::DATA_WIDTH,
  parameter int               LIMB_WIDTH = 64,
  parameter logic [WIDTH-1:0] MODULUS    = WIDTH'(parameters_pkg::MODULUS)
) (
  input  logic        clk,
  input  logic        rst_n,
  mod_addsub_if.slave bus
);

  localparam int NUM_LIMBS = WIDTH / LIMB_WIDTH;
  localparam int CNT_W     = $clog2(NUM_LIMBS + 1);

  generate
    if (WIDTH % LIMB_WIDTH != 0) begin : g_bad_width
      $error("mod_addsub: WIDTH must be a multiple of LIMB_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [LIMB_WIDTH:0] ext_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_q, b_q, p_q;   // operand and modulus, shifted right one limb per cycle
  logic [WIDTH-1:0] s_q, t_q;        // partial results, filled from the top one limb per cycle
  logic [WIDTH-1:0] result_q;
  logic             op_q;
  logic             carry_q, borrow_q;
  logic [CNT_W-1:0] cnt_q;

  logic accept, last_limb;

  assign accept    = bus.start && (state == IDLE || state == DONE);
  assign last_limb = (cnt_q == CNT_W'(NUM_LIMBS - 1));

  // ---------------- limb datapath ----------------
  logic [LIMB_WIDTH-1:0] a_limb, b_limb, p_limb, s_limb, t_limb;
  ext_t                  first_ext, second_ext;
  logic                  carry_next, borrow_next, pick_t;
  logic [WIDTH-1:0]      s_next, t_next;

  assign a_limb = a_q[LIMB_WIDTH-1:0];
  assign b_limb = b_q[LIMB_WIDTH-1:0];
  assign p_limb = p_q[LIMB_WIDTH-1:0];

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    first_ext   = '0;
    second_ext  = '0;
    carry_next  = 1'b0;
    borrow_next = 1'b0;
    if (!op_q) begin
      // add: s = a + b + c, then t = s - p - bw
      first_ext   = {1'b0, a_limb} + {1'b0, b_limb} + ext_t'(carry_q);
      second_ext  = {1'b0, first_ext[LIMB_WIDTH-1:0]} - {1'b0, p_limb} - ext_t'(borrow_q);
      carry_next  = first_ext[LIMB_WIDTH];
      borrow_next = second_ext[LIMB_WIDTH];
    end else begin
      // sub: s = a - b - bw, then t = s + p + c
      first_ext   = {1'b0, a_limb} - {1'b0, b_limb} - ext_t'(borrow_q);
      second_ext  = {1'b0, first_ext[LIMB_WIDTH-1:0]} + {1'b0, p_limb} + ext_t'(carry_q);
      borrow_next = first_ext[LIMB_WIDTH];
      carry_next  = second_ext[LIMB_WIDTH];
    end
  end

  assign s_limb = first_ext[LIMB_WIDTH-1:0];
  assign t_limb = second_ext[LIMB_WIDTH-1:0];

  // New limb enters at the top; after NUM_LIMBS shifts limb 0 sits at the LSB.
  assign s_next = (s_q >> LIMB_WIDTH) | (WIDTH'(s_limb) << (WIDTH - LIMB_WIDTH));
  assign t_next = (t_q >> LIMB_WIDTH) | (WIDTH'(t_limb) << (WIDTH - LIMB_WIDTH));

  // Add: sum overflowed, or sum >= p (no borrow subtracting p) -> reduce.
  // Sub: a < b (final borrow) -> add p back.
  assign pick_t = op_q ? borrow_next : (carry_next | ~borrow_next);

  // ---------------- FSM ----------------
  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples its inputs from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_limb) state_next = DONE;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the wide datapath registers are reset too, because reset must
  // clear result and the chains immediately; these are flops, not a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      s_q      <= '0;
      t_q      <= '0;
      result_q <= '0;
      op_q     <= 1'b0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else if (accept) begin
      a_q      <= bus.a;
      b_q      <= bus.b;
      p_q      <= MODULUS;
      s_q      <= '0;
      t_q      <= '0;
      op_q     <= bus.op;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else if (state == RUN) begin
      a_q      <= a_q >> LIMB_WIDTH;
      b_q      <= b_q >> LIMB_WIDTH;
      p_q      <= p_q >> LIMB_WIDTH;
      s_q      <= s_next;
      t_q      <= t_next;
      carry_q  <= carry_next;
      borrow_q <= borrow_next;
      cnt_q    <= cnt_q + 1'b1;
      if (last_limb) result_q <= pick_t ? t_next : s_next;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = (state == DONE);
  assign bus.busy   = (state == RUN);

endmodule

// File: doc/mod_addsub.md
MOD_ADDSUB -- requirements
Module: mod_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default DATA_WIDTH (448), operand/result width in bits.
REQ-002 SHALL have parameter LIMB_WIDTH, default 64, bits processed per cycle.
REQ-003 SHALL have parameter MODULUS, WIDTH bits, default MODULUS from parameters_pkg (2^448 - 2^224 - 1).
REQ-004 SHALL fail elaboration unless WIDTH % LIMB_WIDTH == 0; NUM_LIMBS = WIDTH/LIMB_WIDTH.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  request; sampled on a rising edge when accepted (see REQ-012).
REQ-008 op  input  1  0 = a+b mod MODULUS, 1 = a-b mod MODULUS.
REQ-009 a, b  input  WIDTH  operands, each required < MODULUS.
REQ-010 result  output  WIDTH  registered result.
REQ-011 done  output  1  one-cycle completion pulse; busy  output  1  high while an operation is in flight.

Function
REQ-012 FSM states IDLE, RUN, DONE; start accepted only in IDLE or DONE; start in RUN ignored, no queueing.
REQ-013 On acceptance SHALL latch a, b, op, clear limb counter, carry and borrow, go RUN; later input changes have no effect on that operation.
REQ-014 RUN SHALL process limb i (bits LIMB_WIDTH*i +: LIMB_WIDTH, LSB first) on its i-th cycle, i = 0..NUM_LIMBS-1.
REQ-015 Add mode per limb: s_i = a_i + b_i + c (carry chain c); t_i = s_i - p_i - bw (borrow chain bw). Final: result = t if final c == 1 or final bw == 0, else s.
REQ-016 Sub mode per limb: s_i = a_i - b_i - bw; t_i = s_i + p_i + c. Final: result = t if final bw == 1, else s.
REQ-017 Carry and borrow chains SHALL be (LIMB_WIDTH+1)-bit limb arithmetic; no WIDTH-wide adder in the datapath.
REQ-018 After the edge processing limb NUM_LIMBS-1, state SHALL be DONE, result updated, done = 1, busy = 0.
REQ-019 Latency: done high in the cycle following the NUM_LIMBS-th edge after the accepting edge (448/64: 7 edges).
REQ-020 done SHALL be high for exactly one cycle; DONE goes to IDLE next edge unless start accepted (then RUN, back-to-back, throughput NUM_LIMBS+1 cycles).
REQ-021 result SHALL hold its value until the next operation completes; it does not change during RUN.
REQ-022 busy SHALL be 1 in RUN only.
REQ-023 Results for operands >= MODULUS are unspecified but SHALL NOT hang the FSM.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, result = 0, done = 0, busy = 0, counter/carry/borrow = 0, regardless of clock.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse; first start after release behaves as from power-up.
REQ-026 start while rst_n low SHALL be ignored.

Verification
REQ-027 Default params: op=0, a=MODULUS-1, b=1 -> result 0, done after 7 edges, one-cycle pulse.
REQ-028 op=0, a=MODULUS-1, b=2 -> result 1; op=0, a=2^447, b=5 -> result 2^447+5 (no reduction).
REQ-029 op=1, a=0, b=1 -> result MODULUS-1; op=1, a=5, b=3 -> result 2.
REQ-030 Start pulsed again during RUN with different operands -> ignored, first result delivered, exactly one done; start in DONE cycle -> second op accepted, done 8 cycles after first.
REQ-031 rst_n low for one cycle at RUN limb 3 -> result 0, no done; subsequent op completes correctly.
REQ-032 WIDTH=16, LIMB_WIDTH=8, MODULUS=65521: 10000 random a,b<65521 both ops vs. (a±b) mod 65521 reference, latency 2 edges.
